// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART receive path: FSM states, parity mode
// encodings, oversampling constants and frame-length normalisation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } rx_state_t;

  localparam logic [1:0]  PARITY_ODD  = 2'b10;
  localparam logic [1:0]  PARITY_EVEN = 2'b11;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  MID_TICK    = 4'd8;

  // Frame lengths outside 5..8 fall back to 8 data bits.
  function automatic logic [3:0] norm_frame_len(input logic [3:0] fl);
    return ((fl >= 4'd5) && (fl <= 4'd8)) ? fl : 4'd8;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx input conditioning: 2-flop synchronizer (resets to the idle level 1)
// and the bit-decision value used for start validation and data sampling.
// With UART_RX_MAJORITY_EN defined, the decision value is a 2-of-3 vote over
// the current and two preceding rx_tick samples of the synchronized line;
// otherwise it is the synchronized line itself.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic rx_s,
  output logic rx_bit
);

  logic [1:0] sync_q;

  // Two-stage synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], din};
  end

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep the two previous tick-instant samples so the vote completes on the
  // sample tick itself, leaving bit timing unchanged.
  always_ff @(posedge clk) begin
    if (rst)       hist_q <= '1;
    else if (tick) hist_q <= {hist_q[0], rx_s};
  end

  assign rx_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign rx_bit      = rx_s;
`endif

endmodule

// File: rtl/uart_receiver.sv
// APB UART receiver: 16x oversampled serial-to-parallel stage that gathers
// the LSB-first frames of one DATA_WIDTH-bit word into read_data and pulses
// RX_done when the word is complete. Optional build macro:
// UART_RX_MAJORITY_EN (2-of-3 vote around mid-bit, applied in uart_rx_sync).
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rx_tick,
  input  logic                  rx_enable,
  input  logic                  Rx,
  input  logic [3:0]            frame_length,
  input  logic [1:0]            parity_signal,
  input  logic                  stop_bits,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  RX_done,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  rx_busy
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [5:0] DW_IDX    = 6'(DATA_WIDTH);

  rx_state_t             state_q, next_state, word_end;
  logic                  rx_s, rx_bit;
  logic [3:0]            tick_cnt_q, bit_cnt_q, fl_q;
  logic [5:0]            word_idx_q;
  logic [1:0]            par_q;
  logic                  stop2_q, par_acc_q;
  logic [DATA_WIDTH-1:0] shift_q, bit_mask;
  logic                  mid_pt, bit_pt, last_data, start_seen, exp_parity;

  uart_rx_sync u_sync (
    .clk    (PCLK),
    .rst    (PRESET),
    .tick   (rx_tick),
    .din    (Rx),
    .rx_s   (rx_s),
    .rx_bit (rx_bit)
  );

  // Sample-point strobes and per-word derived values.
  always_comb begin
    mid_pt     = rx_tick && (tick_cnt_q == MID_TICK - 4'd1);
    bit_pt     = rx_tick && (tick_cnt_q == LAST_TICK);
    last_data  = (bit_cnt_q == fl_q - 4'd1);
    start_seen = rx_tick && !rx_s;
    exp_parity = (par_q == PARITY_EVEN) ? par_acc_q : ~par_acc_q;
    word_end   = (word_idx_q >= DW_IDX) ? DONE : WAIT_START;
    // Positions at or beyond DATA_WIDTH shift out to an all-zero mask, so
    // the transmitter's padding bits never land in the word.
    bit_mask   = DATA_WIDTH'(1) << word_idx_q;
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state = state_q;
    RX_done    = 1'b0;
    rx_busy    = 1'b1;
    case (state_q)
      IDLE: begin
        rx_busy = 1'b0;
        if (rx_enable && start_seen) next_state = START;
      end
      WAIT_START: if (start_seen) next_state = START;
      START: begin
        if (mid_pt) begin
          if (!rx_bit)                 next_state = DATA;
          else if (word_idx_q == '0)   next_state = IDLE;
          else                         next_state = WAIT_START;
        end
      end
      DATA:   if (bit_pt && last_data) next_state = par_q[1] ? PARITY : STOP1;
      PARITY: if (bit_pt) next_state = STOP1;
      STOP1:  if (bit_pt) next_state = stop2_q ? STOP2 : word_end;
      STOP2:  if (bit_pt) next_state = word_end;
      DONE: begin
        RX_done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counters, latched frame format, shift register, sticky errors.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      fl_q         <= 4'd8;
      par_q        <= '0;
      stop2_q      <= 1'b0;
      par_acc_q    <= 1'b0;
      shift_q      <= '0;
      read_data    <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if ((state_q inside {DATA, PARITY, STOP1, STOP2}) && rx_tick)
        tick_cnt_q <= bit_pt ? '0 : tick_cnt_q + 4'd1;

      case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          word_idx_q <= '0;
          if (rx_enable && start_seen) begin
            fl_q         <= norm_frame_len(frame_length);
            par_q        <= parity_signal;
            stop2_q      <= stop_bits;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
          end
        end
        WAIT_START: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
        START: begin
          if (rx_tick) tick_cnt_q <= mid_pt ? '0 : tick_cnt_q + 4'd1;
          par_acc_q <= 1'b0;
        end
        DATA: begin
          if (bit_pt) begin
            shift_q    <= rx_bit ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
            par_acc_q  <= par_acc_q ^ rx_bit;
            word_idx_q <= word_idx_q + 6'd1;
            bit_cnt_q  <= last_data ? '0 : bit_cnt_q + 4'd1;
          end
        end
        PARITY: begin
          if (bit_pt && (rx_bit != exp_parity)) parity_error <= 1'b1;
        end
        STOP1, STOP2: begin
          if (bit_pt && !rx_bit)              frame_error <= 1'b1;
          // Load on the final stop tick so read_data is valid with RX_done.
          if (bit_pt && (next_state == DONE)) read_data   <= shift_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames are generated from a
// word-level description, the expected word/flags are queued at issue time,
// and a monitor pops and compares on every RX_done pulse.
module tb_uart_receiver;

  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          rx_tick = 1'b0;
  logic          rx_enable = 1'b0;
  logic          Rx = 1'b1;
  logic [3:0]    frame_length = 4'd8;
  logic [1:0]    parity_signal = 2'b00;
  logic          stop_bits = 1'b0;
  logic [DW-1:0] read_data;
  logic          RX_done, parity_error, frame_error, rx_busy;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t last_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   tick_div = 0;

  uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(16)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .rx_tick       (rx_tick),
    .rx_enable     (rx_enable),
    .Rx            (Rx),
    .frame_length  (frame_length),
    .parity_signal (parity_signal),
    .stop_bits     (stop_bits),
    .read_data     (read_data),
    .RX_done       (RX_done),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
    .rx_busy       (rx_busy)
  );

  always #5 PCLK = ~PCLK;

  // 16x tick: one PCLK-wide pulse every second cycle.
  initial begin
    forever begin
      @(negedge PCLK);
      tick_div = (tick_div + 1) % 2;
      rx_tick  = (tick_div == 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      while (rx_tick !== 1'b1) @(posedge PCLK);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge PCLK);
    Rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] bits, input int f, input logic [1:0] par,
                            input logic st2, input bit flip, input bit bad_stop);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < f; i++) begin
      send_bit(bits[3'(i)]);
      p = p ^ bits[3'(i)];
    end
    // Even: parity bit = XOR of data; odd: XNOR of data.
    if (par[1]) send_bit((par[0] ? p : ~p) ^ flip);
    send_bit(~bad_stop);
    if (st2) send_bit(1'b1);
  endtask

  // bad_fr is only used with two stop bits so the line is high again right
  // after the corrupted stop bit.
  task automatic send_word(input logic [31:0] w, input logic [3:0] fl_raw, input logic [1:0] par,
                           input logic st2, input int flip_fr, input int bad_fr, input bit scramble);
    int          f, nfr;
    logic [63:0] padded;
    logic [7:0]  bits;
    exp_t        e;
    f      = ((fl_raw >= 4'd5) && (fl_raw <= 4'd8)) ? int'(fl_raw) : 8;
    nfr    = (DW + f - 1) / f;
    padded = {32'h0, w};
    e.data = w;
    e.perr = par[1] && (flip_fr >= 0) && (flip_fr < nfr);
    e.ferr = (bad_fr >= 0) && (bad_fr < nfr);
    frame_length  = fl_raw;
    parity_signal = par;
    stop_bits     = st2;
    exp_q.push_back(e);
    for (int k = 0; k < nfr; k++) begin
      bits = 8'(padded >> (k * f));
      send_frame(bits, f, par, st2, (k == flip_fr), (k == bad_fr));
      if ((k == 0) && scramble) begin
        frame_length  = 4'($urandom_range(0, 15));
        parity_signal = 2'($urandom);
        stop_bits     = 1'($urandom);
      end
      wait_ticks(int'($urandom_range(0, 3)));
    end
  endtask

  // Scoreboard monitor.
  always @(negedge PCLK) begin
    if ((PRESET === 1'b0) && (RX_done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_done_unexpected: RX_done=1 read_data=%h, required no pulse", read_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("read_data", read_data, mon_e.data);
        check("parity_error", 32'(parity_error), 32'(mon_e.perr));
        check("frame_error", 32'(frame_error), 32'(mon_e.ferr));
        last_e = mon_e;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  fl;
    logic [1:0]  par;
    logic        st2;
    int          flip, bad;

    last_e = '0;
    repeat (4) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("reset_read_data", read_data, 32'h0);
    check("reset_rx_done", 32'(RX_done), 32'h0);
    check("reset_parity_error", 32'(parity_error), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);

    rx_enable = 1'b1;
    wait_ticks(4);

    send_word(32'hA5C30F12, 4'd8, 2'b00, 1'b0, -1, -1, 1'b0);
    send_word(32'hFFFFFFFF, 4'd5, 2'b10, 1'b1, -1, -1, 1'b0);
    send_word(32'h12345678, 4'd7, 2'b11, 1'b0,  2, -1, 1'b0);
    send_word(32'h5A5AC3C3, 4'd8, 2'b00, 1'b1, -1,  2, 1'b0);

    // False start: line low for 4 ticks only.
    @(negedge PCLK);
    Rx = 1'b0;
    wait_ticks(4);
    @(negedge PCLK);
    check("false_start_busy_high", 32'(rx_busy), 32'h1);
    Rx = 1'b1;
    wait_ticks(12);
    @(negedge PCLK);
    check("false_start_busy_low", 32'(rx_busy), 32'h0);

    // rx_enable low: a long low level must not start a word.
    rx_enable = 1'b0;
    @(negedge PCLK);
    Rx = 1'b0;
    wait_ticks(20);
    @(negedge PCLK);
    check("disabled_busy", 32'(rx_busy), 32'h0);
    Rx = 1'b1;
    wait_ticks(4);
    rx_enable = 1'b1;
    wait_ticks(2);

    // Reset in the middle of the second frame.
    frame_length  = 4'd8;
    parity_signal = 2'b00;
    stop_bits     = 1'b0;
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge PCLK);
    check("mid_word_busy", 32'(rx_busy), 32'h1);
    Rx     = 1'b1;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("mid_reset_read_data", read_data, 32'h0);
    check("mid_reset_rx_done", 32'(RX_done), 32'h0);
    check("mid_reset_parity_error", 32'(parity_error), 32'h0);
    check("mid_reset_frame_error", 32'(frame_error), 32'h0);
    check("mid_reset_rx_busy", 32'(rx_busy), 32'h0);
    wait_ticks(20);
    send_word(32'h0000BEEF, 4'd8, 2'b00, 1'b0, -1, -1, 1'b0);

    // Randomized words with format changes after the first frame.
    for (int t = 0; t < 10; t++) begin
      w    = $urandom;
      fl   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 8));
      par  = 2'($urandom);
      st2  = 1'($urandom);
      flip = (par[1] && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(0, 3)) : -1;
      bad  = (st2 && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(0, 3)) : -1;
      send_word(w, fl, par, st2, flip, bad, 1'b1);
    end

    for (int i = 0; (i < 2000) && (exp_q.size() != 0); i++) @(negedge PCLK);
    check("words_pending", 32'(exp_q.size()), 32'h0);

    // Outputs hold after delivery until the next start is accepted.
    wait_ticks(40);
    @(negedge PCLK);
    check("hold_read_data", read_data, last_e.data);
    check("hold_parity_error", 32'(parity_error), 32'(last_e.perr));
    check("hold_frame_error", 32'(frame_error), 32'(last_e.ferr));
    check("hold_rx_busy", 32'(rx_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
